// File: rtl/mc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : mc_ctrl_if
// Brief  : Control/status bundle between mc_ctrl and the multi-cycle datapath.
// Rev    : 1.0
// ============================================================================
interface mc_ctrl_if #(
   parameter int CNT_W = 32
) ();
   logic [5:0]       op;
   logic [5:0]       funct;
   logic             zero;
   logic             mem_ready;
   logic             pc_write;
   logic             ir_write;
   logic             iord;
   logic             mem_read;
   logic             mem_write;
   logic             reg_write;
   logic             regdst;
   logic             r31;
   logic             memtoreg;
   logic             alusrc;
   logic             extop;
   logic [2:0]       aluop;
   logic [1:0]       npc_sel;
   logic             trap;
   logic [2:0]       state;
   logic [CNT_W-1:0] retired;

   modport master (
      input  op, funct, zero, mem_ready,
      output pc_write, ir_write, iord, mem_read, mem_write, reg_write, regdst, r31,
             memtoreg, alusrc, extop, aluop, npc_sel, trap, state, retired
   );

   modport slave (
      output op, funct, zero, mem_ready,
      input  pc_write, ir_write, iord, mem_read, mem_write, reg_write, regdst, r31,
             memtoreg, alusrc, extop, aluop, npc_sel, trap, state, retired
   );
endinterface
`default_nettype wire

// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module : mc_ctrl
// Brief  : Multi-cycle MIPS control sequencer (FETCH/DECODE/EXEC/MEM/WB/TRAP).
// Rev    : 1.0
// ============================================================================
module mc_ctrl #(
   parameter int CNT_W    = 32,
   parameter int WAIT_MAX = 16
) (
   input  logic      clock,
   input  logic      reset,
   mc_ctrl_if.master bus
);
   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd7
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   localparam logic [5:0] FN_ADDU  = 6'b100001;
   localparam logic [5:0] FN_SUBU  = 6'b100011;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_SLT   = 6'b101010;
   localparam logic [5:0] FN_JR    = 6'b001000;

   localparam logic [2:0] ALU_ADDU = 3'd0;
   localparam logic [2:0] ALU_SUBU = 3'd1;
   localparam logic [2:0] ALU_AND  = 3'd2;
   localparam logic [2:0] ALU_OR   = 3'd3;
   localparam logic [2:0] ALU_SLT  = 3'd4;
   localparam logic [2:0] ALU_LUI  = 3'd5;

   localparam int                WAIT_W     = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
   localparam bit                TIMEOUT_EN = (WAIT_MAX > 0);
   localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);
   localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

   state_e            state_q;
   logic [CNT_W-1:0]  retired_q;
   logic [WAIT_W-1:0] wait_q;

   logic       op_rtype, op_lw, op_sw, op_beq, op_j, op_jal, op_imm;
   logic       is_r_alu, is_jr, legal, timeout;
   logic [2:0] alu_fn;

   assign op_rtype = (bus.op == OP_RTYPE);
   assign op_lw    = (bus.op == OP_LW);
   assign op_sw    = (bus.op == OP_SW);
   assign op_beq   = (bus.op == OP_BEQ);
   assign op_j     = (bus.op == OP_J);
   assign op_jal   = (bus.op == OP_JAL);
   assign op_imm   = (bus.op == OP_ADDIU) || (bus.op == OP_ORI) || (bus.op == OP_LUI);
   assign legal    = is_r_alu || is_jr || op_imm || op_lw || op_sw || op_beq || op_j || op_jal;
   assign timeout  = TIMEOUT_EN && (wait_q == WAIT_LAST);

   always_comb begin
      is_r_alu = 1'b0;
      is_jr    = 1'b0;
      alu_fn   = ALU_ADDU;
      if (op_rtype) begin
         case (bus.funct)
            FN_ADDU: begin is_r_alu = 1'b1; alu_fn = ALU_ADDU; end
            FN_SUBU: begin is_r_alu = 1'b1; alu_fn = ALU_SUBU; end
            FN_AND:  begin is_r_alu = 1'b1; alu_fn = ALU_AND;  end
            FN_OR:   begin is_r_alu = 1'b1; alu_fn = ALU_OR;   end
            FN_SLT:  begin is_r_alu = 1'b1; alu_fn = ALU_SLT;  end
            FN_JR:   is_jr = 1'b1;
            default: ;
         endcase
      end
      case (bus.op)
         OP_ORI:  alu_fn = ALU_OR;
         OP_LUI:  alu_fn = ALU_LUI;
         OP_BEQ:  alu_fn = ALU_SUBU;
         default: ;
      endcase
   end

   // Wait counter is cleared every cycle unless a memory state stalls again.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= S_FETCH;
         retired_q <= '0;
         wait_q    <= '0;
      end else begin
         wait_q <= '0;
         case (state_q)
            S_FETCH: begin
               if (bus.mem_ready)  state_q <= S_DECODE;
               else if (timeout)   state_q <= S_TRAP;
               else                wait_q  <= wait_q + WAIT_ONE;
            end
            S_DECODE: begin
               if (!legal) begin
                  state_q <= S_TRAP;
               end else if (op_j) begin
                  state_q   <= S_FETCH;
                  retired_q <= retired_q + CNT_ONE;
               end else if (op_jal) begin
                  state_q <= S_WB;
               end else begin
                  state_q <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (op_lw || op_sw) begin
                  state_q <= S_MEM;
               end else if (op_beq || is_jr) begin
                  state_q   <= S_FETCH;
                  retired_q <= retired_q + CNT_ONE;
               end else begin
                  state_q <= S_WB;
               end
            end
            S_MEM: begin
               if (bus.mem_ready) begin
                  if (op_lw) begin
                     state_q <= S_WB;
                  end else begin
                     state_q   <= S_FETCH;
                     retired_q <= retired_q + CNT_ONE;
                  end
               end else if (timeout) begin
                  state_q <= S_TRAP;
               end else begin
                  wait_q <= wait_q + WAIT_ONE;
               end
            end
            S_WB: begin
               state_q   <= S_FETCH;
               retired_q <= retired_q + CNT_ONE;
            end
            default: state_q <= S_TRAP;
         endcase
      end
   end

   assign bus.state   = state_q;
   assign bus.retired = retired_q;

   always_comb begin
      bus.pc_write  = 1'b0;
      bus.ir_write  = 1'b0;
      bus.iord      = 1'b0;
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      bus.reg_write = 1'b0;
      bus.regdst    = 1'b0;
      bus.r31       = 1'b0;
      bus.memtoreg  = 1'b0;
      bus.alusrc    = 1'b0;
      bus.extop     = 1'b0;
      bus.aluop     = ALU_ADDU;
      bus.npc_sel   = 2'b00;
      bus.trap      = 1'b0;
      // ALU controls stay valid from EXEC through WB so no ALUOut latch is needed.
      if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
         bus.aluop  = alu_fn;
         bus.alusrc = op_imm || op_lw || op_sw;
         bus.extop  = (bus.op == OP_ADDIU) || op_lw || op_sw;
      end
      case (state_q)
         S_FETCH: begin
            bus.mem_read = 1'b1;
            bus.ir_write = bus.mem_ready;
            bus.pc_write = bus.mem_ready;
         end
         S_DECODE: begin
            if (op_j) begin
               bus.pc_write = 1'b1;
               bus.npc_sel  = 2'b10;
            end
         end
         S_EXEC: begin
            if (op_beq) begin
               bus.pc_write = bus.zero;
               bus.npc_sel  = 2'b01;
            end else if (is_jr) begin
               bus.pc_write = 1'b1;
               bus.npc_sel  = 2'b11;
            end
         end
         S_MEM: begin
            bus.iord      = 1'b1;
            bus.mem_read  = op_lw;
            bus.mem_write = op_sw;
         end
         S_WB: begin
            bus.reg_write = 1'b1;
            bus.regdst    = is_r_alu;
            bus.memtoreg  = op_lw;
            if (op_jal) begin
               bus.r31      = 1'b1;
               bus.pc_write = 1'b1;
               bus.npc_sel  = 2'b10;
            end
         end
         S_TRAP:  bus.trap = 1'b1;
         default: ;
      endcase
      if (reset) begin
         bus.pc_write  = 1'b0;
         bus.ir_write  = 1'b0;
         bus.mem_read  = 1'b0;
         bus.mem_write = 1'b0;
         bus.reg_write = 1'b0;
         bus.trap      = 1'b0;
      end
   end
endmodule
`default_nettype wire

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle control sequencer for the MIPS datapath (pc, im/dm, gpr, alu, npc, ext).
- Replaces single-cycle combinational decode: drives the shared datapath through FETCH/DECODE/EXEC/MEM/WB states, one instruction at a time.
- Stalls on a unified-memory ready handshake, counts retired instructions, traps on illegal opcodes or memory timeout.

Parameters:
- CNT_W, 32: width of the retired-instruction counter.
- WAIT_MAX, 16: maximum consecutive cycles waiting for mem_ready before trapping; 0 disables the timeout.

Ports:
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- op  in  6  IR[31:26], held by the datapath instruction register
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  PC load enable
- ir_write  out  1  instruction register load enable
- iord  out  1  memory address select: 0 = pc, 1 = ALU result
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- reg_write  out  1  gpr write enable
- regdst  out  1  destination select: 1 = rd, 0 = rt
- r31  out  1  force destination 31 and write data = pc (link)
- memtoreg  out  1  gpr write data select: 1 = memory data, 0 = ALU
- alusrc  out  1  ALU B select: 1 = extended immediate
- extop  out  1  1 = sign-extend, 0 = zero-extend
- aluop  out  3  ALU function code
- npc_sel  out  2  next-pc source: 00 = pc+4, 01 = branch target, 10 = jump index, 11 = register rs
- trap  out  1  controller halted in TRAP
- state  out  3  current state, for debug
- retired  out  CNT_W  count of completed instructions

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
- Reset: state=FETCH, retired=0, wait counter=0. While reset is high, every strobe (pc_write, ir_write, mem_read, mem_write, reg_write) and trap are 0.
- All outputs are Moore decode of the state register plus op/funct; they contain no combinational path from mem_ready except pc_write, ir_write, and the "zero" gating.
- aluop codes: 000 addu, 001 subu, 010 and, 011 or, 100 slt, 101 lui.
- Supported opcodes:
  - R-type 000000, with funct addu 100001, subu 100011, and 100100, or 100101, slt 101010, jr 001000
  - addiu 001001 (extop=1), ori 001101 (extop=0), lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
- FETCH:
  - Asserts mem_read=1, iord=0.
  - On mem_ready: ir_write=1, pc_write=1, npc_sel=00, then go to DECODE. Otherwise remain in FETCH.
- DECODE:
  - j: pc_write=1, npc_sel=10; retire; go to FETCH.
  - jal: go to WB.
  - Illegal op/funct: go to TRAP.
  - All other supported opcodes: go to EXEC.
- EXEC:
  - R-alu: ALU per funct, alusrc=0; go to WB.
  - addiu/ori/lui: alusrc=1; go to WB.
  - lw/sw: aluop=addu, alusrc=1, extop=1; go to MEM.
  - beq: aluop=subu, alusrc=0; pc_write=zero, npc_sel=01; retire; go to FETCH.
  - jr: pc_write=1, npc_sel=11; retire; go to FETCH.
- MEM:
  - iord=1. lw asserts mem_read; sw asserts mem_write.
  - Hold until mem_ready. Then lw goes to WB; sw retires and goes to FETCH.
- WB:
  - reg_write=1.
  - R-type: regdst=1. Immediates: regdst=0. lw: regdst=0, memtoreg=1.
  - jal: r31=1, pc_write=1, npc_sel=10. The link value is the pc already incremented in FETCH.
  - Retire; go to FETCH.
- Retire: retired increments by 1 on the cycle the final state is exited. It wraps modulo 2^CNT_W.
- Memory timeout: the wait counter counts consecutive cycles in FETCH/MEM with mem_ready=0 and clears on mem_ready or state change. If WAIT_MAX>0 and the count reaches WAIT_MAX, go to TRAP.
- TRAP: trap=1, all strobes 0, retired frozen; exit only via reset.
- Reset asserted mid-instruction: aborts immediately; no strobe is asserted in the reset cycle; the next cycle is FETCH.
- mem_ready high in a state that does not access memory is ignored.

Test Plan:
- Reset, then addu (op 0, funct 100001) with mem_ready always 1 -> state sequence 0,1,2,4,0; reg_write=1 only in state 4 with regdst=1, aluop=000; retired=1 after 4 cycles.
- lw with mem_ready low for 3 cycles in MEM -> MEM held 4 cycles with mem_read=1, iord=1; WB has memtoreg=1, regdst=0; total 8 cycles; retired increments once.
- beq with zero=1, then beq with zero=0 -> in EXEC, pc_write=1 with npc_sel=01 for the first, pc_write=0 for the second; each instruction takes 3 cycles.
- jal -> sequence 0,1,4; WB has reg_write=1, r31=1, pc_write=1, npc_sel=10. Then j -> sequence 0,1 with pc_write=1, npc_sel=10 in DECODE.
- op=111111 -> TRAP after DECODE; trap=1 and strobes 0 for 20 cycles; reset returns state=0, retired=0.
- mem_ready held 0 in FETCH with WAIT_MAX=16 -> TRAP reached after exactly 16 waiting cycles. Reset asserted during MEM of a sw -> mem_write=0 in the reset cycle, FETCH next.
